// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory / burst-fetch block.
//   fetch_state_t : burst engine states (IDLE, FETCH, DRAIN)
//   next_addr()   : pointer increment with wrap from depth-1 back to 0.
//                   An explicit compare is used so depths that are not a
//                   power of two wrap correctly.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int unsigned next_addr(input int unsigned ptr,
                                            input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/prog_mem_fetch_if.sv
// Instruction stream from the fetch engine to the decode stage.
//   instr       : fetched word
//   instr_valid : instr holds a word not yet accepted
//   instr_ready : consumer accepts instr
// Handshake: a word transfers on a rising edge where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0 the source
// keeps instr and instr_valid stable; instr_valid may drop only after a
// transfer or on an abort/reset.
interface prog_mem_fetch_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (output instr, output instr_valid, input  instr_ready);
  modport slave  (input  instr, input  instr_valid, output instr_ready);
endinterface

// File: rtl/prog_mem_array.sv
// Program storage: DEPTH words of DATA_W bits.
//   clk, rstn              : clock, async active-low clear of every word
//   wr_enable/addr/data    : host write port (out-of-range address ignored)
//   host_addr / host_data  : combinational read port for the host
//   fetch_addr / fetch_data: combinational read port for the fetch engine
// Both read ports are write-first: a same-cycle write to the read address
// is forwarded. Out-of-range read addresses return 0.
module prog_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_ok;

  assign w_wr_ok = wr_enable && (32'(wr_addr) < DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    host_data = '0;
    if (32'(host_addr) < DEPTH) begin
      if (w_wr_ok && (wr_addr == host_addr)) host_data = wr_data;
      else                                   host_data = r_mem[host_addr];
    end
  end

  always_comb begin
    fetch_data = '0;
    if (32'(fetch_addr) < DEPTH) begin
      if (w_wr_ok && (wr_addr == fetch_addr)) fetch_data = wr_data;
      else                                    fetch_data = r_mem[fetch_addr];
    end
  end

endmodule

// File: rtl/prog_mem_fetch.sv
// Program memory with host load/read port and autonomous burst fetch.
//   clk, rstn                    : clock, async active-low reset
//   wr_enable, wr_addr, acc_data : host write
//   rd_enable, rd_addr           : host read request (ignored while busy)
//   rd_data, rd_valid            : registered read data + one-cycle pulse
//   fetch_start/base/len         : start a burst (sampled in IDLE only)
//   fetch_abort                  : cancel a running burst, no fetch_done
//   fetch_if (master)            : instr / instr_valid / instr_ready stream
//   fetch_busy                   : engine not IDLE
//   fetch_done                   : one-cycle pulse after normal completion
//   dbg_state                    : current engine state
module prog_mem_fetch
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_enable,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  acc_data,
  input  logic               rd_enable,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  input  logic               fetch_start,
  input  logic               fetch_abort,
  input  logic [ADDR_W-1:0]  fetch_base,
  input  logic [LEN_W-1:0]   fetch_len,
  prog_mem_fetch_if.master   fetch_if,
  output logic               fetch_busy,
  output logic               fetch_done,
  output fetch_state_t       dbg_state
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_count;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_done;

  logic [DATA_W-1:0] w_host_data;
  logic [DATA_W-1:0] w_fetch_data;
  logic              w_host_rd;
  logic              w_slot_free;
  logic              w_load;
  logic              w_zero_done;
  logic              w_advance;
  logic              w_drain_done;
  logic              w_abort;

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk        (clk),
    .rstn       (rstn),
    .wr_enable  (wr_enable),
    .wr_addr    (wr_addr),
    .wr_data    (acc_data),
    .host_addr  (rd_addr),
    .host_data  (w_host_data),
    .fetch_addr (r_ptr),
    .fetch_data (w_fetch_data)
  );

  // Host reads share nothing with the engine, but are blocked while busy so
  // the host never observes memory mid-burst.
  assign w_host_rd = rd_enable && (r_state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_free  = !r_instr_valid || fetch_if.instr_ready;
    w_load       = 1'b0;
    w_zero_done  = 1'b0;
    w_advance    = 1'b0;
    w_drain_done = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (fetch_start) begin
          if (fetch_len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_zero_done = 1'b1;
          end
        end
      end
      FETCH: begin
        // Abort wins over any handshake in the same cycle.
        if (fetch_abort) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_slot_free) begin
          w_advance = 1'b1;
          if (r_count == LEN_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fetch_abort) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (fetch_if.instr_ready) begin
          w_drain_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr         <= '0;
      r_count       <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done     <= w_zero_done || w_drain_done;
      r_rd_valid <= w_host_rd;
      if (w_host_rd) r_rd_data <= w_host_data;
      if (w_load) begin
        r_ptr   <= fetch_base;
        r_count <= fetch_len;
      end
      if (w_advance) begin
        r_instr       <= w_fetch_data;
        r_instr_valid <= 1'b1;
        r_count       <= r_count - LEN_W'(1);
        r_ptr         <= ADDR_W'(next_addr(32'(r_ptr), DEPTH));
      end
      if (w_abort || w_drain_done) r_instr_valid <= 1'b0;
    end
  end

  assign rd_data              = r_rd_data;
  assign rd_valid             = r_rd_valid;
  assign fetch_if.instr       = r_instr;
  assign fetch_if.instr_valid = r_instr_valid;
  assign fetch_busy           = (r_state != IDLE);
  assign fetch_done           = r_done;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Directed bench for prog_mem_fetch: host load/read, bursts with wrap,
// back-pressure, zero and full length, collision, abort and async reset.
module tb_prog_mem_fetch;
  import prog_mem_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  logic              clk;
  logic              rstn;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] acc_data;
  logic              rd_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              fetch_start;
  logic              fetch_abort;
  logic [ADDR_W-1:0] fetch_base;
  logic [LEN_W-1:0]  fetch_len;
  logic              fetch_busy;
  logic              fetch_done;
  fetch_state_t      dbg_state;

  prog_mem_fetch_if #(.DATA_W(DATA_W)) fif ();

  prog_mem_fetch #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_enable   (wr_enable),
    .wr_addr     (wr_addr),
    .acc_data    (acc_data),
    .rd_enable   (rd_enable),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fetch_start (fetch_start),
    .fetch_abort (fetch_abort),
    .fetch_base  (fetch_base),
    .fetch_len   (fetch_len),
    .fetch_if    (fif),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int                n_total = 0;
  int                n_bad   = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input int d);
    wr_enable = 1'b1;
    wr_addr   = ADDR_W'(a);
    acc_data  = DATA_W'(d);
    step();
    wr_enable = 1'b0;
    model[a]  = DATA_W'(d);
  endtask

  task automatic host_read(input string tag, input int a, input int exp);
    rd_enable = 1'b1;
    rd_addr   = ADDR_W'(a);
    step();
    rd_enable = 1'b0;
    check({tag, "_data"}, 32'(rd_data), exp);
    check({tag, "_valid"}, 32'(rd_valid), 1);
    step();
    check({tag, "_pulse"}, 32'(rd_valid), 0);
    check({tag, "_hold"}, 32'(rd_data), exp);
  endtask

  // Runs one burst; stall_n cycles of instr_ready=0 are inserted while
  // word number stall_idx is presented.
  task automatic run_burst(input string tag, input int base, input int len,
                           input int stall_idx, input int stall_n);
    int cyc;
    int accepted;
    int stalls;
    cyc = 0; accepted = 0; stalls = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(model[(base + i) % DEPTH]);
    fif.instr_ready = 1'b1;
    fetch_base  = ADDR_W'(base);
    fetch_len   = LEN_W'(len);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check({tag, "_busy"}, 32'(fetch_busy), (len != 0) ? 1 : 0);
    while (!fetch_done && cyc < 64) begin
      if (fif.instr_valid) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, 1, 0);
        else                   check({tag, "_instr"}, 32'(fif.instr), 32'(exp_q[0]));
        if (accepted == stall_idx && stalls < stall_n) begin
          fif.instr_ready = 1'b0;
          stalls++;
        end else begin
          fif.instr_ready = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          accepted++;
        end
      end else begin
        fif.instr_ready = 1'b1;
      end
      step();
      cyc++;
    end
    check({tag, "_done"}, 32'(fetch_done), 1);
    check({tag, "_count"}, accepted, len);
    check({tag, "_cycles"}, cyc, (len == 0) ? 0 : len + 1 + stall_n);
    check({tag, "_valid_end"}, 32'(fif.instr_valid), 0);
    check({tag, "_idle"}, 32'(fetch_busy), 0);
    step();
    check({tag, "_done_pulse"}, 32'(fetch_done), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; wr_enable = 1'b0; wr_addr = '0; acc_data = '0;
    rd_enable = 1'b0; rd_addr = '0; fetch_start = 1'b0; fetch_abort = 1'b0;
    fetch_base = '0; fetch_len = '0; fif.instr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step(); step();
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_instr", 32'(fif.instr), 0);
    check("rst_instr_valid", 32'(fif.instr_valid), 0);
    check("rst_busy", 32'(fetch_busy), 0);
    check("rst_done", 32'(fetch_done), 0);
    rstn = 1'b1;
    step();

    host_write(3, 89);
    host_write(8, 46);
    host_read("rd3", 3, 89);
    host_read("rd8", 8, 46);
    host_read("rd5", 5, 0);

    for (int i = 0; i < DEPTH; i++) host_write(i, 'h10 + i);
    run_burst("wrap", 14, 4, -1, 0);
    run_burst("stall", 14, 4, 1, 3);
    run_burst("zero", 7, 0, -1, 0);
    run_burst("full", 5, 16, -1, 0);

    // Same-cycle write and read of one address forwards the new data.
    wr_enable = 1'b1; wr_addr = 4'd5; acc_data = 8'd23;
    rd_enable = 1'b1; rd_addr = 4'd5;
    step();
    wr_enable = 1'b0; rd_enable = 1'b0;
    model[5] = 8'd23;
    check("coll_data", 32'(rd_data), 23);
    check("coll_valid", 32'(rd_valid), 1);

    // Busy-time host read is dropped, then abort mid-burst.
    fif.instr_ready = 1'b0;
    fetch_base = 4'd0; fetch_len = 5'd4; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    check("ab_valid", 32'(fif.instr_valid), 1);
    check("ab_instr", 32'(fif.instr), 32'(model[0]));
    rd_enable = 1'b1; rd_addr = 4'd3;
    step();
    rd_enable = 1'b0;
    check("busy_rd_valid", 32'(rd_valid), 0);
    check("busy_rd_hold", 32'(rd_data), 23);
    check("ab_instr_hold", 32'(fif.instr), 32'(model[0]));
    fetch_abort = 1'b1; fif.instr_ready = 1'b1;
    step();
    fetch_abort = 1'b0;
    check("ab_valid_low", 32'(fif.instr_valid), 0);
    check("ab_busy_low", 32'(fetch_busy), 0);
    check("ab_no_done", 32'(fetch_done), 0);
    step();
    check("ab_no_done2", 32'(fetch_done), 0);

    // Async reset during a burst.
    fetch_base = 4'd2; fetch_len = 5'd16; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step(); step();
    check("mr_valid_pre", 32'(fif.instr_valid), 1);
    check("mr_busy_pre", 32'(fetch_busy), 1);
    rstn = 1'b0;
    #1;
    check("mr_instr", 32'(fif.instr), 0);
    check("mr_valid", 32'(fif.instr_valid), 0);
    check("mr_busy", 32'(fetch_busy), 0);
    check("mr_rd_data", 32'(rd_data), 0);
    check("mr_done", 32'(fetch_done), 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step();
    check("mr_done_after", 32'(fetch_done), 0);
    host_read("mr_rd3", 3, 0);
    host_read("mr_rd5", 5, 0);
    host_read("mr_rd15", 15, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_mem_fetch.md
Name: prog_mem_fetch

Overview:
Parametrised program memory with a host load/read port and an autonomous burst-fetch engine. The engine streams instructions to the decode stage over a ready/valid handshake. It replaces the fixed 16x8 program store in the generalised processor. The host loads code through the write port, then issues a fetch burst (base, length); the engine walks the memory with wrap-around and supports back-pressure and abort.

Parameters:
DATA_W, 8, instruction/data word width
DEPTH, 16, number of words (need not be a power of 2, must be >= 2)
ADDR_W, $clog2(DEPTH), address width (derived)
LEN_W, ADDR_W+1, burst-length width; allows lengths 0..DEPTH (derived)

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
wr_enable  in  1  host write strobe
wr_addr  in  ADDR_W  host write address
acc_data  in  DATA_W  host write data (accumulator)
rd_enable  in  1  host read strobe
rd_addr  in  ADDR_W  host read address
rd_data  out  DATA_W  host read data, registered
rd_valid  out  1  one-cycle pulse, rd_data updated
fetch_start  in  1  start burst (sampled in IDLE only)
fetch_abort  in  1  cancel burst
fetch_base  in  ADDR_W  first burst address
fetch_len  in  LEN_W  burst word count
instr  out  DATA_W  fetched word
instr_valid  out  1  instr valid
instr_ready  in  1  consumer accepts instr
fetch_busy  out  1  state != IDLE
fetch_done  out  1  one-cycle pulse, burst completed normally

Behaviour:
- Reset (async, rstn=0): all DEPTH words = 0; rd_data=0, rd_valid=0, instr=0, instr_valid=0, fetch_busy=0, fetch_done=0; state=IDLE; ptr=0, count=0.
- Write: wr_enable=1 and wr_addr<DEPTH -> mem[wr_addr]<=acc_data at the edge. wr_addr>=DEPTH is ignored. Writes are legal in every state.
- Host read: rd_enable=1 and fetch_busy=0 -> rd_data<=mem[rd_addr] at the edge, rd_valid=1 for that cycle. rd_addr>=DEPTH returns 0. While fetch_busy=1, rd_enable is ignored: no rd_valid, rd_data holds.
- Read/write collision on the same address in the same cycle is write-first: rd_data/instr gets acc_data.
- rd_data holds its last value when no read occurs.
- States: IDLE, FETCH, DRAIN.
- IDLE: fetch_start=1 and fetch_len!=0 -> ptr<=fetch_base, count<=fetch_len, go to FETCH.
- IDLE: fetch_start=1 and fetch_len==0 -> fetch_done pulses in the following cycle; stay in IDLE.
- FETCH: output slot is "free" when instr_valid=0 or instr_ready=1.
- FETCH, slot free: instr<=mem[ptr], instr_valid<=1, count<=count-1, ptr<=ptr+1; ptr wraps from DEPTH-1 to 0 by explicit compare. When count==1, go to DRAIN.
- FETCH, slot not free: instr, instr_valid, ptr and count all hold. instr must stay stable while instr_valid=1 and instr_ready=0.
- DRAIN: when instr_ready=1, instr_valid<=0, fetch_done<=1 for one cycle, go to IDLE. Otherwise hold.
- Latency: fetch_start sampled at edge E0 -> instr=mem[base] valid after E1. With instr_ready held at 1, one word per cycle. The last word is accepted at edge E_len+1, and fetch_done is high for the cycle after that edge.
- fetch_start while busy is ignored.
- fetch_abort in FETCH or DRAIN: next edge sets instr_valid=0 and state=IDLE; no fetch_done. Abort has priority over a simultaneous handshake. Abort in IDLE has no effect.
- A write to the address being fetched takes effect for any read not yet performed. Words already in instr are not updated.
- A reset during a burst returns to the reset values immediately. No fetch_done is produced.

Decomposition:
- Package prog_mem_pkg: state enum (IDLE, FETCH, DRAIN); function next_addr(ptr) implementing the wrap.
- One sub-module, prog_mem_array: storage, async clear, write port, and two combinational write-first read ports (host, fetch).
- The FSM, handshake and output registers stay in prog_mem_fetch.

Test Plan:
- Reset, then write 89@3, 46@8; host read 3 -> rd_data=89, rd_valid high 1 cycle; read 8 -> 46; unwritten 5 -> 0.
- Load 0x10..0x1F into addr 0..15; fetch base=14, len=4, ready=1 -> instr 0x1E,0x1F,0x10,0x11 on consecutive cycles (wrap); fetch_done 1 cycle after the last is accepted.
- Same burst with instr_ready low for 3 cycles on the 2nd word -> instr holds 0x1F stable; the sequence is unchanged; count is correct.
- fetch_len=0 -> fetch_done pulse, instr_valid never rises. fetch_len=16 -> all 16 words; the burst ends at base-1.
- Write 23@5 and read 5 in the same cycle -> rd_data=23. During a burst, rd_enable -> no rd_valid. fetch_abort mid-burst -> instr_valid=0 next cycle, no fetch_done, fetch_busy=0.
- rstn asserted mid-burst -> all outputs 0 asynchronously; memory reads back 0 afterward.
